// File: rtl/fp_operand_seq_if.sv
// Operand and result bundle between the switch/button side,
// the sequencer and the combinational adder core.
interface fp_operand_seq_if;
  logic        btn_tick;
  logic [12:0] sw;
  logic        sign1;
  logic [3:0]  exp1;
  logic [7:0]  frac1;
  logic        sign2;
  logic [3:0]  exp2;
  logic [7:0]  frac2;
  logic        sum_sign;
  logic [3:0]  sum_exp;
  logic [7:0]  sum_frac;
  logic        sign_out;
  logic [3:0]  exp_out;
  logic [7:0]  frac_out;
  logic        result_valid;
  logic [1:0]  phase;

  modport slave (
    input  btn_tick,
    input  sw,
    input  sum_sign,
    input  sum_exp,
    input  sum_frac,
    output sign1,
    output exp1,
    output frac1,
    output sign2,
    output exp2,
    output frac2,
    output sign_out,
    output exp_out,
    output frac_out,
    output result_valid,
    output phase
  );

  modport master (
    output btn_tick,
    output sw,
    output sum_sign,
    output sum_exp,
    output sum_frac,
    input  sign1,
    input  exp1,
    input  frac1,
    input  sign2,
    input  exp2,
    input  frac2,
    input  sign_out,
    input  exp_out,
    input  frac_out,
    input  result_valid,
    input  phase
  );
endinterface

// File: rtl/fp_operand_seq.sv
// Operand entry, per-cycle normalization and timed result
// capture around the combinational floating-point adder.
module fp_operand_seq #(
  parameter int unsigned ADD_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  fp_operand_seq_if.slave   bus
);

  localparam logic [3:0] WAIT_L = 4'(ADD_WAIT);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_NORM_A,
    S_WAIT_B,
    S_NORM_B,
    S_ADD,
    S_DONE
  } state_e;

  state_e      state_q;
  state_e      state_d;

  logic        a_sign_q;
  logic [3:0]  a_exp_q;
  logic [7:0]  a_frac_q;
  logic        b_sign_q;
  logic [3:0]  b_exp_q;
  logic [7:0]  b_frac_q;
  logic        o_sign_q;
  logic [3:0]  o_exp_q;
  logic [7:0]  o_frac_q;
  logic [3:0]  cnt_q;
  logic        valid_q;
  logic [1:0]  phase_q;

  logic        op_sign;
  logic [3:0]  op_exp;
  logic [7:0]  op_frac;
  logic        n_sign_d;
  logic [3:0]  n_exp_d;
  logic [7:0]  n_frac_d;
  logic        n_exit;

  logic        load_a;
  logic        load_b;
  logic        add_last;
  logic [1:0]  phase_d;

  assign load_a = bus.btn_tick &&
                  (state_q == S_WAIT_A || state_q == S_DONE);
  assign load_b = bus.btn_tick && (state_q == S_WAIT_B);
  assign add_last = (state_q == S_ADD) && (cnt_q <= 4'd1);

  // One normalization step on whichever operand is in NORM.
  always_comb begin
    op_sign = a_sign_q;
    op_exp  = a_exp_q;
    op_frac = a_frac_q;
    if (state_q == S_NORM_B) begin
      op_sign = b_sign_q;
      op_exp  = b_exp_q;
      op_frac = b_frac_q;
    end
    n_sign_d = op_sign;
    n_exp_d  = op_exp;
    n_frac_d = op_frac;
    n_exit   = 1'b0;
    if (op_frac == 8'd0) begin
      n_sign_d = 1'b0;
      n_exp_d  = 4'd0;
      n_exit   = 1'b1;
    end else if (op_frac[7] || op_exp == 4'd0) begin
      n_exit   = 1'b1;
    end else begin
      n_frac_d = {op_frac[6:0], 1'b0};
      n_exp_d  = op_exp - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT_A: if (bus.btn_tick) state_d = S_NORM_A;
      S_NORM_A: if (n_exit)       state_d = S_WAIT_B;
      S_WAIT_B: if (bus.btn_tick) state_d = S_NORM_B;
      S_NORM_B: if (n_exit)       state_d = S_ADD;
      S_ADD:    if (add_last)     state_d = S_DONE;
      S_DONE:   if (bus.btn_tick) state_d = S_NORM_A;
      default:                    state_d = S_WAIT_A;
    endcase
  end

  always_comb begin
    phase_d = 2'd0;
    unique case (1'b1)
      (state_d == S_WAIT_B),
      (state_d == S_NORM_B): phase_d = 2'd1;
      (state_d == S_ADD):    phase_d = 2'd2;
      (state_d == S_DONE):   phase_d = 2'd3;
      default:               phase_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_WAIT_A;
      a_sign_q <= 1'b0;
      a_exp_q  <= 4'd0;
      a_frac_q <= 8'd0;
      b_sign_q <= 1'b0;
      b_exp_q  <= 4'd0;
      b_frac_q <= 8'd0;
      o_sign_q <= 1'b0;
      o_exp_q  <= 4'd0;
      o_frac_q <= 8'd0;
      cnt_q    <= 4'd0;
      valid_q  <= 1'b0;
      phase_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == S_DONE);
      phase_q <= phase_d;
      if (load_a) begin
        {a_sign_q, a_exp_q, a_frac_q} <= bus.sw;
      end else if (state_q == S_NORM_A) begin
        a_sign_q <= n_sign_d;
        a_exp_q  <= n_exp_d;
        a_frac_q <= n_frac_d;
      end
      if (load_b) begin
        {b_sign_q, b_exp_q, b_frac_q} <= bus.sw;
      end else if (state_q == S_NORM_B) begin
        b_sign_q <= n_sign_d;
        b_exp_q  <= n_exp_d;
        b_frac_q <= n_frac_d;
      end
      // Counter is armed on the NORM_B exit so ADD lasts ADD_WAIT cycles.
      if (state_q == S_NORM_B && n_exit) begin
        cnt_q <= WAIT_L;
      end else if (state_q == S_ADD) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (add_last) begin
        o_sign_q <= bus.sum_sign;
        o_exp_q  <= bus.sum_exp;
        o_frac_q <= bus.sum_frac;
      end
    end
  end

  assign bus.sign1        = a_sign_q;
  assign bus.exp1         = a_exp_q;
  assign bus.frac1        = a_frac_q;
  assign bus.sign2        = b_sign_q;
  assign bus.exp2         = b_exp_q;
  assign bus.frac2        = b_frac_q;
  assign bus.sign_out     = o_sign_q;
  assign bus.exp_out      = o_exp_q;
  assign bus.frac_out     = o_frac_q;
  assign bus.result_valid = valid_q;
  assign bus.phase        = phase_q;

endmodule

// File: doc/fp_operand_seq.md
# fp_operand_seq

Sequential operand-entry and result-capture stage wrapped around the combinational enhanced floating-point adder core. It collects two 13-bit operands from the switch bank on successive button ticks and normalizes each one over multiple cycles. It then drives the adder inputs, waits a programmable settle time, and registers the sum for the hex/seven-segment display path. It replaces hard-wired switch-to-adder assignments in the board-level test circuit.

## Interface
- `ADD_WAIT`, default 1: clock cycles held in ADD before the adder outputs are captured (1–15).
- `clk`  input  1  system clock, rising-edge.
- `reset`  input  1  synchronous, active-low reset; sampled on the `clk` rising edge while 0.
- `btn_tick`  input  1  one-cycle pulse from an already debounced button.
- `sw`  input  13  operand entry `{sign, exp[3:0], frac[7:0]}`.
- `sign1`, `exp1`, `frac1`  output  1/4/8  registered operand A to the adder.
- `sign2`, `exp2`, `frac2`  output  1/4/8  registered operand B to the adder.
- `sum_sign`, `sum_exp`, `sum_frac`  input  1/4/8  adder result, combinational from the adder core.
- `sign_out`, `exp_out`, `frac_out`  output  1/4/8  captured result.
- `result_valid`  output  1  high while the state is DONE.
- `phase`  output  2  display hint: 0 entering A, 1 entering B, 2 busy, 3 result shown.

## Operation
- States: WAIT_A, NORM_A, WAIT_B, NORM_B, ADD, DONE.
- **WAIT_A**
  - On `btn_tick`, load `sw` into the A registers and go to NORM_A.
  - Otherwise hold.
- **NORM_A / NORM_B**, evaluated once per cycle on the operand being normalized:
  - If frac == 0: force exp = 0 and sign = 0, then leave the state.
  - Else if frac[7] == 1 or exp == 0: leave the state.
  - Else: frac <= frac << 1 and exp <= exp − 1, then stay.
  - Exit from NORM_A goes to WAIT_B; exit from NORM_B goes to ADD.
- **WAIT_B**: on `btn_tick`, load `sw` into the B registers and go to NORM_B.
- **ADD**
  - A 4-bit counter is loaded with `ADD_WAIT` on entry and decrements each cycle.
  - When the counter reaches 1, capture `sum_*` into `*_out` and go to DONE.
- **DONE**
  - `result_valid` = 1.
  - On `btn_tick`, load `sw` into the A registers and go to NORM_A.
  - B registers and `*_out` hold until overwritten.
- `btn_tick` is ignored in NORM_A, NORM_B and ADD. It is not queued.
- Exp arithmetic is unsigned 4-bit. Normalization never decrements below 0, so there is no wrap.
- `phase` mapping:
  - WAIT_A and NORM_A → 0.
  - WAIT_B and NORM_B → 1.
  - ADD → 2.
  - DONE → 3.

## Timing
- Reset (`reset` = 0 at a rising edge):
  - State = WAIT_A.
  - All operand registers and `*_out` = 0.
  - `result_valid` = 0, `phase` = 0.
- Reset has priority over `btn_tick` in the same cycle. Reset mid-operation in any state aborts the operation with the same values.
- Operand load: `sw` is sampled on the edge where `btn_tick` = 1. The new value is visible on `sign1`/`exp1`/`frac1` (or the B outputs) on the next cycle.
- Normalization latency: 1 + k cycles in NORM_x, where k is the number of shifts (0 ≤ k ≤ 7). The shift count is bounded by the exp underflow rule.
- ADD latency: exactly `ADD_WAIT` cycles. The capture edge is the last ADD cycle.
- `result_valid` rises the cycle after capture. It falls the cycle after the `btn_tick` that starts a new entry in DONE.
- Adder inputs are stable for the whole ADD state. Operand registers change only in WAIT/NORM states.
- End-to-end: from the B `btn_tick` to `result_valid` = 1 takes (1 + kB) + `ADD_WAIT` + 1 cycles.

## Test plan
- **Reset values:** hold `reset` = 0 for 2 cycles, then release → state WAIT_A, all outputs 0, `phase` = 0. Assert `reset` = 0 during ADD → next cycle WAIT_A and `result_valid` = 0.
- **Basic add:** A = `{0,4'h2,8'h80}`, B = `{0,4'h2,8'h80}`, `ADD_WAIT` = 1, with a behavioural adder model → `exp_out` = 3, `frac_out` = 0x80, `sign_out` = 0. `result_valid` is high exactly 3 cycles after the B tick.
- **Normalization:** enter A = `{0,4'h5,8'h10}` → exactly 4 cycles in NORM_A, ending with `exp1` = 2 and `frac1` = 0x80. Enter B = `{1,4'h1,8'h10}` → 1 shift, ending with `exp2` = 0 and `frac2` = 0x20 (underflow stop).
- **Zero operand:** enter B = `{1,4'h9,8'h00}` → `sign2` = 0, `exp2` = 0, `frac2` = 0 after 1 NORM_B cycle.
- **Ignored ticks:**
  - Pulse `btn_tick` during NORM_A and during ADD → no state skip and no operand change.
  - Run with `ADD_WAIT` = 4 → exactly 4 ADD cycles.
- **Restart from DONE:** while DONE, pulse `btn_tick` with `sw` = `{0,4'h3,8'hC0}` → `result_valid` drops and `phase` = 0. `exp1` = 3 and `frac1` = 0xC0. The previous `*_out` values hold until the next capture.
